pio_out_ctrl: RTL and testbench
===============================

PIO_OUT_CTRL -- requirements
Module: pio_out_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning output port width, legal 1..32.
REQ-002 SHALL have parameter RESET_VALUE, default 3'b111 (zero-extended to WIDTH), meaning data register value after reset.
REQ-003 SHALL have parameter PCNT_W, default 16, meaning pulse length counter width, legal 1..32.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  write strobe, active-low.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  read data, zero wait states, combinational from address.
REQ-011 SHALL have port out_port  output  WIDTH  driven port value.

Function
REQ-012 A write SHALL occur in a cycle with chipselect=1, write_n=0; at most one write per cycle.
REQ-013 Register map: 0 DATA (rw), 2 SET (wo), 3 CLR (wo), 4 PLEN (rw, PCNT_W bits), 5 PULSE (wo), 6 STATUS (ro, bit0=busy); addresses 1 and 7 are reserved.
REQ-014 A DATA write SHALL load data_out <= writedata[WIDTH-1:0].
REQ-015 A SET write SHALL perform data_out <= data_out | writedata[WIDTH-1:0].
REQ-016 A CLR write SHALL perform data_out <= data_out & ~writedata[WIDTH-1:0].
REQ-017 out_port SHALL equal data_out ^ pulse_mask, a combinational XOR of two registers.
REQ-018 Pulse FSM states SHALL be IDLE and ACTIVE; IDLE holds pulse_mask=0, cnt=0.
REQ-019 On a PULSE write with PLEN!=0 and writedata[WIDTH-1:0]!=0, from either state: pulse_mask <= writedata[WIDTH-1:0], cnt <= PLEN, state <= ACTIVE.
REQ-020 A PULSE write with PLEN=0 or mask=0 SHALL be ignored and leave current state untouched.
REQ-021 In ACTIVE without a new PULSE write, cnt SHALL decrement each cycle; at cnt==1 the next state SHALL be IDLE with pulse_mask <= 0.
REQ-022 The masked bits SHALL be inverted for exactly PLEN cycles, starting the edge after the PULSE write.
REQ-023 A PULSE write in the expiry cycle SHALL take priority over expiry (restart).
REQ-024 DATA/SET/CLR writes during ACTIVE SHALL update data_out immediately; inversion continues on the new value.
REQ-025 A PLEN write during ACTIVE SHALL NOT affect the running count.
REQ-026 Reads SHALL return the register zero-extended to 32 bits; SET, CLR, PULSE and reserved addresses read 0; STATUS bit0=(state==ACTIVE).

Reset
REQ-027 While reset_n=0 at a clk edge: data_out <= RESET_VALUE, PLEN <= 0, pulse_mask <= 0, cnt <= 0, state <= IDLE.
REQ-028 Reset asserted during ACTIVE SHALL abort the pulse; out_port = RESET_VALUE the edge after.
REQ-029 Before the first clk edge with reset_n=0, out_port is undefined; no asynchronous path exists.

Configuration
REQ-030 Macro PIO_OUT_PULSE_EN defined: PLEN, PULSE, STATUS and the FSM are built as specified.
REQ-031 Macro PIO_OUT_PULSE_EN undefined: no pulse logic; addresses 4/5/6 read 0, writes ignored; out_port = data_out.

Structure
REQ-032 Package pio_out_pkg SHALL hold the register offset constants (ADDR_DATA..ADDR_STATUS) and FSM state encoding (ST_IDLE, ST_ACTIVE).
REQ-033 Pulse FSM, counter and mask SHALL live in sub-module pio_pulse_timer, instantiated only under PIO_OUT_PULSE_EN.

Verification
REQ-034 Reset with WIDTH=3 -> out_port=3'b111, readdata@0=7, STATUS=0.
REQ-035 DATA=5, SET=2, CLR=4 -> out_port 3'b101, 3'b111, 3'b011 on the successive edges.
REQ-036 DATA=0, PLEN=4, PULSE=3'b001 -> out_port=1 for exactly 4 cycles, then 0; STATUS=1 during, 0 after.
REQ-037 PLEN=10, PULSE=1; PULSE=2 written 3 cycles later -> bit0 reverts, bit1 inverted for 10 cycles from the second write; same at expiry cycle restarts.
REQ-038 PLEN=0, PULSE=7 -> no change on out_port, STATUS stays 0; reset asserted mid-pulse -> out_port=RESET_VALUE next edge.
REQ-039 Build without PIO_OUT_PULSE_EN: PULSE=7 -> out_port unchanged; read of addresses 4/5/6 returns 0.

Source files
------------

// File: rtl/pio_out_ctrl_pkg.sv
// Register offsets and pulse FSM encoding shared by the PIO output controller files.
package pio_out_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd2;
  localparam logic [2:0] ADDR_CLR    = 3'd3;
  localparam logic [2:0] ADDR_PLEN   = 3'd4;
  localparam logic [2:0] ADDR_PULSE  = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/pio_out_ctrl_if.sv
// Avalon-MM slave bus of the PIO output controller (zero wait states, word addressed).
interface pio_out_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_pulse_timer.sv
// Pulse length register, inversion mask and down-counter FSM that times a pulse of PLEN cycles.
module pio_pulse_timer
  import pio_out_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              plen_we,
  input  logic [PCNT_W-1:0] plen_wdata,
  input  logic              pulse_we,
  input  logic [WIDTH-1:0]  pulse_wdata,
  output logic [PCNT_W-1:0] plen,
  output logic [WIDTH-1:0]  pulse_mask,
  output logic              busy
);

  pulse_state_t      state;
  logic [PCNT_W-1:0] cnt;
  logic              pulse_go;

  // A pulse request with zero length or empty mask is dropped without touching the FSM.
  assign pulse_go = pulse_we && (plen != '0) && (pulse_wdata != '0);
  assign busy     = (state == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pulse_mask <= '0;
      plen       <= '0;
    end else begin
      if (plen_we) begin
        plen <= plen_wdata;
      end
      if (pulse_go) begin
        // A new request restarts the pulse, even in the cycle it would have expired.
        pulse_mask <= pulse_wdata;
        cnt        <= plen;
        state      <= ST_ACTIVE;
      end else begin
        case (state)
          ST_ACTIVE: begin
            if (cnt == PCNT_W'(1)) begin
              state      <= ST_IDLE;
              pulse_mask <= '0;
              cnt        <= '0;
            end else begin
              cnt <= cnt - PCNT_W'(1);
            end
          end
          default: begin
            pulse_mask <= '0;
            cnt        <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pio_out_ctrl.sv
// PIO output port with DATA/SET/CLR access and, when PIO_OUT_PULSE_EN is defined,
// a timed inversion pulse (PLEN/PULSE/STATUS registers).
module pio_out_ctrl
  import pio_out_pkg::*;
#(
  parameter int          WIDTH       = 3,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0007,
  parameter int          PCNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_out_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] out_port
);

  logic              wr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  data_out;
  logic [WIDTH-1:0]  pulse_mask;
  logic [PCNT_W-1:0] plen;
  logic              busy;
  logic [31:0]       data_ext;
  logic [31:0]       plen_ext;
  logic              unused_wdata;

  assign wr           = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA: data_out <= wdata;
        ADDR_SET:  data_out <= data_out | wdata;
        ADDR_CLR:  data_out <= data_out & ~wdata;
        default:   ;
      endcase
    end
  end

`ifdef PIO_OUT_PULSE_EN
  pio_pulse_timer #(
    .WIDTH  (WIDTH),
    .PCNT_W (PCNT_W)
  ) u_pulse_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .plen_we     (wr && (bus.address == ADDR_PLEN)),
    .plen_wdata  (bus.writedata[PCNT_W-1:0]),
    .pulse_we    (wr && (bus.address == ADDR_PULSE)),
    .pulse_wdata (wdata),
    .plen        (plen),
    .pulse_mask  (pulse_mask),
    .busy        (busy)
  );
`else
  assign plen       = '0;
  assign pulse_mask = '0;
  assign busy       = 1'b0;
`endif

  assign out_port = data_out ^ pulse_mask;

  always_comb begin
    data_ext              = '0;
    data_ext[WIDTH-1:0]   = data_out;
    plen_ext              = '0;
    plen_ext[PCNT_W-1:0]  = plen;
  end

  // Write-only and reserved offsets fall through to zero.
  always_comb begin
    case (bus.address)
      ADDR_DATA:   bus.readdata = data_ext;
      ADDR_PLEN:   bus.readdata = plen_ext;
      ADDR_STATUS: bus.readdata = {31'b0, busy};
      default:     bus.readdata = 32'b0;
    endcase
  end

endmodule

// File: tb/tb_pio_out_ctrl.sv
// Directed bench for pio_out_ctrl (WIDTH=3); pulse scenarios run when PIO_OUT_PULSE_EN is defined.
module tb_pio_out_ctrl;

  logic       clk;
  logic       reset_n;
  logic [2:0] out_port;
  int         checks;
  int         errors;
  logic [31:0] rv;

  pio_out_ctrl_if bus ();

  pio_out_ctrl #(
    .WIDTH       (3),
    .RESET_VALUE (32'h7),
    .PCNT_W      (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    #1;
    d              = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    repeat (2) step();

    chk("reset_out", {29'b0, out_port}, 32'h7);
    rd(3'd0, rv); chk("reset_data_rd", rv, 32'h7);
    rd(3'd6, rv); chk("reset_status", rv, 32'h0);
    rd(3'd4, rv); chk("reset_plen", rv, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    wr(3'd0, 32'h5); chk("data_5", {29'b0, out_port}, 32'h5);
    wr(3'd2, 32'h2); chk("set_2", {29'b0, out_port}, 32'h7);
    wr(3'd3, 32'h4); chk("clr_4", {29'b0, out_port}, 32'h3);
    rd(3'd0, rv);    chk("data_rd_3", rv, 32'h3);
    wr(3'd0, 32'hFFFF_FFF8); chk("data_trunc", {29'b0, out_port}, 32'h0);
    wr(3'd0, 32'h6); chk("data_6", {29'b0, out_port}, 32'h6);

    @(negedge clk);
    bus.address = 3'd0; bus.writedata = 32'h1; bus.chipselect = 1'b0; bus.write_n = 1'b0;
    step();
    bus.write_n = 1'b1;
    chk("no_cs_write", {29'b0, out_port}, 32'h6);
    wr(3'd1, 32'h1); chk("reserved_wr", {29'b0, out_port}, 32'h6);
    rd(3'd1, rv); chk("reserved_rd1", rv, 32'h0);
    rd(3'd7, rv); chk("reserved_rd7", rv, 32'h0);
    rd(3'd2, rv); chk("set_rd", rv, 32'h0);
    rd(3'd3, rv); chk("clr_rd", rv, 32'h0);

`ifdef PIO_OUT_PULSE_EN
    // Basic 4-cycle pulse on bit0.
    wr(3'd0, 32'h0);
    wr(3'd4, 32'h4);
    rd(3'd4, rv); chk("plen_rd_4", rv, 32'h4);
    wr(3'd5, 32'h1);
    chk("p4_c1", {29'b0, out_port}, 32'h1);
    rd(3'd6, rv); chk("p4_status_on", rv, 32'h1);
    for (int i = 2; i <= 4; i++) begin
      step(); chk($sformatf("p4_c%0d", i), {29'b0, out_port}, 32'h1);
    end
    step(); chk("p4_end", {29'b0, out_port}, 32'h0);
    rd(3'd6, rv); chk("p4_status_off", rv, 32'h0);

    // Restart with a different mask three cycles in.
    wr(3'd4, 32'd10);
    wr(3'd5, 32'h1);
    chk("rs_a0", {29'b0, out_port}, 32'h1);
    step(); chk("rs_a1", {29'b0, out_port}, 32'h1);
    step(); chk("rs_a2", {29'b0, out_port}, 32'h1);
    wr(3'd5, 32'h2);
    chk("rs_b1", {29'b0, out_port}, 32'h2);
    for (int i = 2; i <= 10; i++) begin
      step(); chk($sformatf("rs_b%0d", i), {29'b0, out_port}, 32'h2);
    end
    step(); chk("rs_end", {29'b0, out_port}, 32'h0);

    // Restart written in the expiry cycle wins.
    wr(3'd4, 32'd2);
    wr(3'd5, 32'h4);
    chk("ex_a1", {29'b0, out_port}, 32'h4);
    step(); chk("ex_a2", {29'b0, out_port}, 32'h4);
    wr(3'd5, 32'h1);
    chk("ex_b1", {29'b0, out_port}, 32'h1);
    rd(3'd6, rv); chk("ex_status", rv, 32'h1);
    step(); chk("ex_b2", {29'b0, out_port}, 32'h1);
    step(); chk("ex_end", {29'b0, out_port}, 32'h0);

    // PLEN write mid-pulse leaves the running count alone.
    wr(3'd4, 32'd3);
    wr(3'd5, 32'h2);
    chk("pl_1", {29'b0, out_port}, 32'h2);
    wr(3'd4, 32'd8);
    chk("pl_2", {29'b0, out_port}, 32'h2);
    step(); chk("pl_3", {29'b0, out_port}, 32'h2);
    step(); chk("pl_end", {29'b0, out_port}, 32'h0);
    rd(3'd4, rv); chk("pl_rd_8", rv, 32'h8);

    // Zero length or zero mask is ignored.
    wr(3'd4, 32'd0);
    wr(3'd5, 32'h7);
    chk("plen0_out", {29'b0, out_port}, 32'h0);
    rd(3'd6, rv); chk("plen0_status", rv, 32'h0);
    wr(3'd4, 32'd5);
    wr(3'd5, 32'h1);
    wr(3'd5, 32'h0);
    chk("mask0_keeps", {29'b0, out_port}, 32'h1);
    rd(3'd6, rv); chk("mask0_status", rv, 32'h1);

    // DATA write during the pulse, then reset aborts it.
    wr(3'd0, 32'h4);
    chk("data_in_pulse", {29'b0, out_port}, 32'h5);
    @(negedge clk);
    reset_n = 1'b0;
    step();
    chk("rst_abort_out", {29'b0, out_port}, 32'h7);
    rd(3'd6, rv); chk("rst_abort_status", rv, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(); chk("rst_abort_hold", {29'b0, out_port}, 32'h7);
`else
    wr(3'd0, 32'h0);
    wr(3'd4, 32'h4);
    wr(3'd5, 32'h7);
    chk("nopulse_out", {29'b0, out_port}, 32'h0);
    step(); chk("nopulse_out2", {29'b0, out_port}, 32'h0);
    rd(3'd4, rv); chk("nopulse_rd4", rv, 32'h0);
    rd(3'd5, rv); chk("nopulse_rd5", rv, 32'h0);
    rd(3'd6, rv); chk("nopulse_rd6", rv, 32'h0);
    wr(3'd0, 32'h4);
    @(negedge clk);
    reset_n = 1'b0;
    step(); chk("rst_out", {29'b0, out_port}, 32'h7);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
